naive_bus_dma: RTL
==================

NAIVE_BUS_DMA -- requirements
Module: naive_bus_dma

Interface
- REQ-001 SHALL have parameter LEN_W, default 16: width of the transfer-length input, in words.
- REQ-002 SHALL have port clk, input, 1: the single clock; every register samples on its rising edge.
- REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-004 SHALL have port bus, naive_bus.master modport: rd_req/rd_gnt/rd_addr[31:0]/rd_data[31:0] and wr_req/wr_gnt/wr_addr[31:0]/wr_data[31:0]/wr_be[3:0].
- REQ-005 SHALL have port i_start, input, 1: start request, sampled only in IDLE.
- REQ-006 SHALL have port i_src, input, 32: source byte address.
- REQ-007 SHALL have port i_dst, input, 32: destination byte address.
- REQ-008 SHALL have port i_len, input, LEN_W: word count.
- REQ-009 SHALL have port o_busy, output, 1: high in every state except IDLE.
- REQ-010 SHALL have port o_done, output, 1: one-cycle completion pulse.

Function
- REQ-011 SHALL implement the FSM IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> (RD_REQ | DONE) -> IDLE.
- REQ-012 SHALL, in IDLE with i_start=1, latch src/dst with bits[1:0] forced to 0, latch i_len, and enter RD_REQ; if i_len=0, enter DONE instead with no bus traffic.
- REQ-013 SHALL drive rd_req=1 with rd_addr=src_ptr in RD_REQ, holding both stable until rd_gnt=1, then go to RD_WAIT.
- REQ-014 SHALL, in RD_WAIT, capture rd_data into a 32-bit holding register and go to WR_REQ (the slave returns read data one cycle after the grant).
- REQ-015 SHALL drive wr_req=1, wr_addr=dst_ptr, wr_data=holding register and wr_be=4'hF in WR_REQ, holding them stable until wr_gnt=1.
- REQ-016 SHALL, on that write grant, add 4 to both pointers (modulo 2^32, wrap-around permitted), decrement the remaining count, and go to DONE if the count reaches 0, otherwise to RD_REQ.
- REQ-017 SHALL drive o_done=1 for exactly one cycle in DONE, then return to IDLE.
- REQ-018 SHALL ignore i_start whenever the FSM is not in IDLE, and SHALL not change the latched parameters while busy.
- REQ-019 SHALL never assert rd_req and wr_req in the same cycle; outside their request states both SHALL be 0 and addr/data SHALL be 0.
- REQ-020 SHALL, with grants tied to requests, copy at 3 cycles per word: start sampled in cycle 0 gives o_done in cycle 3N+1.

Reset
- REQ-021 SHALL, while rst=1, force the state to IDLE, all bus outputs to 0, o_busy=0, o_done=0, and pointers, count and holding register to 0.
- REQ-022 SHALL, on reset mid-transfer, deassert all requests in the next cycle and abandon the transfer with no o_done.

Configuration
- REQ-023 SHALL, when macro NAIVE_BUS_DMA_FILL_EN is defined, add inputs i_fill (1 bit) and i_pattern (32 bits), latched with i_start.
- REQ-024 SHALL, when i_fill=1, go directly IDLE -> WR_REQ, write i_pattern to N consecutive words at 1 cycle per granted word with no read traffic, and assert o_done in cycle N+1.
- REQ-025 SHALL, when NAIVE_BUS_DMA_FILL_EN is undefined, omit i_fill and i_pattern and always copy.

Verification
- REQ-026 SHALL cover: src=0x000, dst=0x100, len=4, grants tied to requests, RAM preloaded with 0x11111111..0x44444444 -> four reads at 0x000/0x004/0x008/0x00C, matching writes at 0x100..0x10C, o_done in cycle 13.
- REQ-027 SHALL cover: len=0 -> o_done in cycle 1, rd_req and wr_req never asserted.
- REQ-028 SHALL cover: rd_gnt held low for 3 cycles on word 2 -> rd_req and rd_addr=0x004 stay stable, copied data is correct, o_done is delayed by 3 cycles.
- REQ-029 SHALL cover: src=0xFFFFFFFC, len=2 -> second read at 0x00000000 (wrap-around); i_src=0x103 -> first read at 0x100.
- REQ-030 SHALL cover: rst=1 pulsed during the WR_REQ of word 2 -> requests are 0 in the next cycle, no o_done, and a fresh start afterwards copies correctly.
- REQ-031 SHALL cover, with FILL_EN defined: fill pattern=0xDEADBEEF, dst=0x200, len=3 -> writes only to 0x200/0x204/0x208, o_done in cycle 4.

Source files
------------

// File: rtl/naive_bus_dma_if.sv
// naive_bus: simple request/grant bus, separate read and write channels
// Ports (master view):
//   rd_req/rd_addr out, rd_gnt/rd_data in  -- read: data returns the cycle after grant
//   wr_req/wr_addr/wr_data/wr_be out, wr_gnt in -- write: accepted on grant
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_gnt, rd_data, wr_gnt
    );
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/naive_bus_dma.sv
// naive_bus_dma: word-by-word memory copy engine on a naive_bus master port
// Ports:
//   clk, rst          -- clock, synchronous active-high reset
//   bus               -- naive_bus master (read then write per word)
//   i_start           -- start request, sampled only when idle
//   i_src, i_dst      -- byte addresses, low two bits ignored
//   i_len             -- number of 32-bit words to move (0 = immediate done)
//   i_fill, i_pattern -- only with NAIVE_BUS_DMA_FILL_EN: write i_pattern instead of copying
//   o_busy            -- high whenever not idle
//   o_done            -- one-cycle completion pulse
// Build option: define NAIVE_BUS_DMA_FILL_EN to add the pattern-fill mode.
module naive_bus_dma #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    naive_bus.master         bus,
    input  logic             i_start,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
`ifdef NAIVE_BUS_DMA_FILL_EN
    input  logic             i_fill,
    input  logic [31:0]      i_pattern,
`endif
    output logic             o_busy,
    output logic             o_done
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;
    state_t           state;
    logic [31:0]      src_ptr, dst_ptr, hold;
    logic [LEN_W-1:0] count;
    logic             rd_req, wr_req;
    logic [31:0]      rd_addr, wr_addr, wr_data;
    logic [3:0]       wr_be;
    logic [31:0]      src_al, dst_al;
    logic             fill, start_fill;
    logic [31:0]      start_pat;
    assign src_al = i_src & ~32'h3;
    assign dst_al = i_dst & ~32'h3;
`ifdef NAIVE_BUS_DMA_FILL_EN
    assign start_fill = i_fill;
    assign start_pat  = i_pattern;
`else
    assign start_fill = 1'b0;
    assign start_pat  = '0;
    assign fill       = 1'b0;
`endif
    assign bus.rd_req  = rd_req;
    assign bus.rd_addr = rd_addr;
    assign bus.wr_req  = wr_req;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.wr_be   = wr_be;
    // Bus outputs default to idle/zero each cycle; each state re-asserts
    // what the following cycle must present, so all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            hold    <= '0;
            rd_req  <= 1'b0;
            rd_addr <= '0;
            wr_req  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_be   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
`ifdef NAIVE_BUS_DMA_FILL_EN
            fill    <= 1'b0;
`endif
        end else begin
            rd_req  <= 1'b0;
            rd_addr <= '0;
            wr_req  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_be   <= '0;
            o_done  <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    src_ptr <= src_al;
                    dst_ptr <= dst_al;
                    count   <= i_len;
                    hold    <= start_pat;
                    o_busy  <= 1'b1;
`ifdef NAIVE_BUS_DMA_FILL_EN
                    fill    <= start_fill;
`endif
                    if (i_len == '0) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else if (start_fill) begin
                        state   <= WR_REQ;
                        wr_req  <= 1'b1;
                        wr_addr <= dst_al;
                        wr_data <= start_pat;
                        wr_be   <= 4'hF;
                    end else begin
                        state   <= RD_REQ;
                        rd_req  <= 1'b1;
                        rd_addr <= src_al;
                    end
                end
                RD_REQ: begin
                    state   <= bus.rd_gnt ? RD_WAIT : RD_REQ;
                    rd_req  <= !bus.rd_gnt;
                    rd_addr <= bus.rd_gnt ? '0 : src_ptr;
                end
                RD_WAIT: begin
                    hold    <= bus.rd_data;
                    state   <= WR_REQ;
                    wr_req  <= 1'b1;
                    wr_addr <= dst_ptr;
                    wr_data <= bus.rd_data;
                    wr_be   <= 4'hF;
                end
                WR_REQ: if (!bus.wr_gnt) begin
                    wr_req  <= 1'b1;
                    wr_addr <= dst_ptr;
                    wr_data <= hold;
                    wr_be   <= 4'hF;
                end else begin
                    src_ptr <= src_ptr + 32'd4;
                    dst_ptr <= dst_ptr + 32'd4;
                    count   <= count - LEN_W'(1);
                    if (count == LEN_W'(1)) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else if (fill) begin
                        wr_req  <= 1'b1;
                        wr_addr <= dst_ptr + 32'd4;
                        wr_data <= hold;
                        wr_be   <= 4'hF;
                    end else begin
                        state   <= RD_REQ;
                        rd_req  <= 1'b1;
                        rd_addr <= src_ptr + 32'd4;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
